// File: rtl/sipo_deserializer.sv
// sipo_deserializer
//   Serial-in, parallel-out deserializer. Bits arrive LSB first on sin when
//   ena is high; every WIDTH accepted bits form one word that is presented on
//   dout with a valid/ready handshake. A word completing while the previous
//   one is still unaccepted is dropped and flagged on the sticky overrun bit.
//
// Ports
//   clk         in   clock, rising edge
//   areset      in   asynchronous active-high reset
//   clear       in   synchronous frame restart (drops partial word, valid, overrun)
//   ena         in   sin carries a valid bit this cycle
//   sin         in   serial data, LSB of each word first
//   dout        out  [WIDTH-1:0] last completed word
//   dout_valid  out  dout holds a word not yet accepted
//   dout_ready  in   consumer accepts dout when dout_valid is high
//   overrun     out  sticky: a completed word was dropped
//   busy        out  a partial word is held
module sipo_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             clear,
    input  logic             ena,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] word;
    logic             complete;

    always_comb begin
        sreg_d       = sreg_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;

        word     = {sin, sreg_q[WIDTH-1:1]};
        complete = ena && (cnt_q == LAST_BIT);

        if (clear) begin
            // Clear wins over everything; dout itself is deliberately kept.
            sreg_d       = '0;
            cnt_d        = '0;
            dout_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            if (ena) begin
                sreg_d = word;
                cnt_d  = complete ? '0 : cnt_q + CW'(1);
            end

            // A handshake this cycle frees the slot; a completion on the
            // same edge may refill it immediately.
            if (dout_valid_q && dout_ready) begin
                dout_valid_d = 1'b0;
            end

            if (complete) begin
                if (!dout_valid_q || dout_ready) begin
                    dout_d       = word;
                    dout_valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sreg_q       <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (cnt_q != '0);

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the number of serial bits per word (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port areset, input, 1 bit: asynchronous active-high reset to zero.
REQ-004 SHALL have port clear, input, 1 bit: synchronous restart of the frame; discards the partial word, dout_valid and overrun.
REQ-005 SHALL have port ena, input, 1 bit: sin holds a valid serial bit this cycle.
REQ-006 SHALL have port sin, input, 1 bit: serial data, LSB of each word first.
REQ-007 SHALL have port dout, output, WIDTH bits: last completed word.
REQ-008 SHALL have port dout_valid, output, 1 bit: dout holds a word not yet accepted.
REQ-009 SHALL have port dout_ready, input, 1 bit: consumer accepts dout on any cycle where dout_valid=1 and dout_ready=1.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag, a completed word was dropped.
REQ-011 SHALL have port busy, output, 1 bit: a partial word is held (bit count nonzero).

Function
REQ-012 SHALL keep an internal WIDTH-bit shift register and a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-013 SHALL, on a rising edge with ena=1 and clear=0, shift right with sin entering the MSB: sreg <= {sin, sreg[WIDTH-1:1]}, and increment the counter.
REQ-014 SHALL hold sreg and the counter unchanged when ena=0.
REQ-015 SHALL treat the edge that samples the WIDTH-th bit as word completion: the completed word is {sin, sreg[WIDTH-1:1]} and the counter returns to 0 at that edge.
REQ-016 SHALL, on completion with the output slot free (dout_valid=0, or dout_valid=1 with dout_ready=1 that cycle), load dout with the completed word and set dout_valid=1 at that same edge (zero added latency).
REQ-017 SHALL, on completion with dout_valid=1 and dout_ready=0, keep dout and dout_valid unchanged, drop the new word and set overrun=1.
REQ-018 SHALL, on dout_valid=1 and dout_ready=1 with no completion, clear dout_valid at that edge; dout keeps its last value.
REQ-019 SHALL keep dout stable while dout_valid=1 and no handshake occurs.
REQ-020 SHALL ignore dout_ready while dout_valid=0.
REQ-021 SHALL keep overrun at 1 until clear or areset; a further drop while overrun=1 leaves it at 1.
REQ-022 SHALL give clear priority over ena and dout_ready: at the clearing edge sreg, the counter, dout_valid and overrun go to 0, dout is unchanged and the sampled bit is discarded.
REQ-023 SHALL drive busy = (counter != 0) combinationally from registered state.
REQ-024 SHALL accept back-to-back words with ena held high continuously, completing one word every WIDTH cycles with no gap bit.

Reset
REQ-025 SHALL, while areset=1, immediately force sreg, counter, dout, dout_valid, overrun and busy to 0, independent of clk.
REQ-026 SHALL abandon a partial word on reset mid-frame; the first ena bit after reset release is bit 0 of a new word.
REQ-027 SHALL resume normal operation on the first rising clk edge after areset falls.

Verification (WIDTH=4)
REQ-028 Bench SHALL check single word: ena=1 for 4 cycles, sin=1,0,1,1 -> dout=4'b1101 and dout_valid=1 after the 4th edge; busy=1 after edges 1-3 and 0 after edge 4.
REQ-029 Bench SHALL check ena gaps: bits 0,1 then ena=0 for 3 cycles then bits 1,0 -> dout=4'b0110; sreg and counter held during the gaps.
REQ-030 Bench SHALL check overrun: dout_ready=0, two words 4'hA then 4'h5 -> dout stays 4'hA, overrun=1; then dout_ready=1 for one cycle -> dout_valid=0, overrun stays 1.
REQ-031 Bench SHALL check simultaneous accept and complete: dout_valid=1 with dout=4'h3, dout_ready=1 on the edge completing 4'hC -> dout=4'hC, dout_valid=1, overrun=0.
REQ-032 Bench SHALL check reset mid-frame: areset pulsed after 2 bits, asynchronously (between edges) -> all outputs 0 at once; next 4 bits 1,1,1,0 -> dout=4'b0111.
REQ-033 Bench SHALL check clear with ena: clear=1 and ena=1 on the same edge after 3 bits -> busy=0, dout_valid=0, overrun=0; the sampled bit is dropped and the next 4 bits form a whole word.
